// File: rtl/pipe_stage_regs.sv
// IF/ID, ID/EX and EX/MEM pipeline registers of the RV32 core. Obeys hazard_unit's
// stall/flush/interrupt requests, captures the interrupt return PC and counts events.
module pipe_stage_regs #(
  parameter int          XLEN  = 32,
  parameter logic [31:0] NOP   = 32'h0000_0013,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst_fetch,
  input  logic [XLEN-1:0]  pc_fetch,
  input  logic             fetch_valid,
  input  logic             reg_wr_dec,
  input  logic             mem_read_dec,
  input  logic             stall,
  input  logic             flush_sel,
  input  logic             interupt_sel,
  output logic [31:0]      inst_dec,
  output logic [XLEN-1:0]  pc_dec,
  output logic [31:0]      inst_exec,
  output logic [XLEN-1:0]  pc_exec,
  output logic             mem_read,
  output logic [31:0]      inst_mem,
  output logic             reg_wr,
  output logic             valid_exec,
  output logic             valid_mem,
  output logic [XLEN-1:0]  epc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ADV_NORMAL = 2'd0,
    ADV_STALL  = 2'd1,
    ADV_FLUSH  = 2'd2,
    ADV_IRQ    = 2'd3
  } adv_e;

  localparam logic [XLEN-1:0]  PC_ZERO = {XLEN{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = CNT_MAX;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  logic [31:0]      inst_dec_q,  inst_dec_d;
  logic [XLEN-1:0]  pc_dec_q,    pc_dec_d;
  logic             valid_dec_q, valid_dec_d;
  logic [31:0]      inst_exec_q, inst_exec_d;
  logic [XLEN-1:0]  pc_exec_q,   pc_exec_d;
  logic             valid_exec_q, valid_exec_d;
  logic             mem_read_q,  mem_read_d;
  logic             reg_wr_exec_q, reg_wr_exec_d;
  logic [31:0]      inst_mem_q,  inst_mem_d;
  logic             valid_mem_q, valid_mem_d;
  logic             reg_wr_mem_q, reg_wr_mem_d;
  logic [XLEN-1:0]  epc_q,       epc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  adv_e             mode_s;

  // Resolve this cycle's pipeline action: interrupt > flush > stall > advance.
  always_comb begin
    if (interupt_sel) begin
      mode_s = ADV_IRQ;
    end else if (flush_sel) begin
      mode_s = ADV_FLUSH;
    end else if (stall) begin
      mode_s = ADV_STALL;
    end else begin
      mode_s = ADV_NORMAL;
    end
  end

  // Next-state for every stage register, counter and the return PC.
  always_comb begin
    inst_dec_d    = inst_dec_q;
    pc_dec_d      = pc_dec_q;
    valid_dec_d   = valid_dec_q;
    inst_exec_d   = NOP;
    pc_exec_d     = PC_ZERO;
    valid_exec_d  = 1'b0;
    mem_read_d    = 1'b0;
    reg_wr_exec_d = 1'b0;
    // The oldest stage always drains, whatever happens in front of it.
    inst_mem_d    = inst_exec_q;
    valid_mem_d   = valid_exec_q;
    reg_wr_mem_d  = reg_wr_exec_q;
    epc_d         = epc_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;

    case (mode_s)
      ADV_IRQ, ADV_FLUSH: begin
        inst_dec_d  = NOP;
        pc_dec_d    = PC_ZERO;
        valid_dec_d = 1'b0;
        flush_cnt_d = sat_inc(flush_cnt_q);
      end
      ADV_STALL: begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end
      ADV_NORMAL: begin
        inst_dec_d    = inst_fetch;
        pc_dec_d      = pc_fetch;
        valid_dec_d   = fetch_valid;
        inst_exec_d   = inst_dec_q;
        pc_exec_d     = pc_dec_q;
        valid_exec_d  = valid_dec_q;
        mem_read_d    = mem_read_dec & valid_dec_q;
        reg_wr_exec_d = reg_wr_dec & valid_dec_q;
      end
      default: begin
        stall_cnt_d = stall_cnt_q;
      end
    endcase

    // Return to the oldest instruction that has not yet been squashed.
    if (mode_s == ADV_IRQ) begin
      if (valid_exec_q) begin
        epc_d = pc_exec_q;
      end else if (valid_dec_q) begin
        epc_d = pc_dec_q;
      end else begin
        epc_d = pc_fetch;
      end
    end else begin
      epc_d = epc_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_dec_q    <= NOP;
      pc_dec_q      <= PC_ZERO;
      valid_dec_q   <= 1'b0;
      inst_exec_q   <= NOP;
      pc_exec_q     <= PC_ZERO;
      valid_exec_q  <= 1'b0;
      mem_read_q    <= 1'b0;
      reg_wr_exec_q <= 1'b0;
      inst_mem_q    <= NOP;
      valid_mem_q   <= 1'b0;
      reg_wr_mem_q  <= 1'b0;
      epc_q         <= PC_ZERO;
      stall_cnt_q   <= {CNT_W{1'b0}};
      flush_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      inst_dec_q    <= inst_dec_d;
      pc_dec_q      <= pc_dec_d;
      valid_dec_q   <= valid_dec_d;
      inst_exec_q   <= inst_exec_d;
      pc_exec_q     <= pc_exec_d;
      valid_exec_q  <= valid_exec_d;
      mem_read_q    <= mem_read_d;
      reg_wr_exec_q <= reg_wr_exec_d;
      inst_mem_q    <= inst_mem_d;
      valid_mem_q   <= valid_mem_d;
      reg_wr_mem_q  <= reg_wr_mem_d;
      epc_q         <= epc_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign inst_dec   = inst_dec_q;
  assign pc_dec     = pc_dec_q;
  assign inst_exec  = inst_exec_q;
  assign pc_exec    = pc_exec_q;
  assign mem_read   = mem_read_q;
  assign inst_mem   = inst_mem_q;
  assign reg_wr     = reg_wr_mem_q;
  assign valid_exec = valid_exec_q;
  assign valid_mem  = valid_mem_q;
  assign epc        = epc_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Randomised and directed bench for pipe_stage_regs, checked every cycle against
// a slot-level behavioural model of the three pipeline stages.
module tb_pipe_stage_regs;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          SAT = 65535;

  logic        clk;
  logic        reset;
  logic [31:0] inst_fetch, pc_fetch;
  logic        fetch_valid, reg_wr_dec, mem_read_dec, stall, flush_sel, interupt_sel;
  logic [31:0] inst_dec, pc_dec, inst_exec, pc_exec, inst_mem, epc;
  logic        mem_read, reg_wr, valid_exec, valid_mem;
  logic [15:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int n_cmp = 0;
  int miscompares = 0;

  pipe_stage_regs dut (
    .clk(clk), .reset(reset),
    .inst_fetch(inst_fetch), .pc_fetch(pc_fetch), .fetch_valid(fetch_valid),
    .reg_wr_dec(reg_wr_dec), .mem_read_dec(mem_read_dec),
    .stall(stall), .flush_sel(flush_sel), .interupt_sel(interupt_sel),
    .inst_dec(inst_dec), .pc_dec(pc_dec), .inst_exec(inst_exec), .pc_exec(pc_exec),
    .mem_read(mem_read), .inst_mem(inst_mem), .reg_wr(reg_wr),
    .valid_exec(valid_exec), .valid_mem(valid_mem), .epc(epc),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One pipeline slot: what an instruction carries between stages.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        v;
    logic        rw;
    logic        mr;
  } slot_t;

  // s[0]=IF/ID, s[1]=ID/EX, s[2]=EX/MEM; counters kept as plain integers.
  typedef struct packed {
    slot_t       s0;
    slot_t       s1;
    slot_t       s2;
    logic [31:0] epc;
    int          sc;
    int          fc;
  } model_t;

  model_t m;

  function automatic slot_t bubble();
    slot_t b;
    b = '0;
    b.inst = NOP;
    return b;
  endfunction

  function automatic int sat_add(input int x);
    return (x < SAT) ? x + 1 : SAT;
  endfunction

  function automatic model_t reset_model();
    model_t r;
    r = '0;
    r.s0 = bubble();
    r.s1 = bubble();
    r.s2 = bubble();
    return r;
  endfunction

  function automatic model_t step(input model_t c);
    model_t n;
    slot_t  f;
    logic   kill;
    n = c;
    kill = interupt_sel | flush_sel;
    f = '0;
    f.inst = inst_fetch;
    f.pc = pc_fetch;
    f.v = fetch_valid;
    n.s2 = c.s1;
    if (kill) begin
      n.s0 = bubble();
      n.s1 = bubble();
      n.fc = sat_add(c.fc);
    end else if (stall) begin
      n.s1 = bubble();
      n.sc = sat_add(c.sc);
    end else begin
      n.s1 = c.s0;
      n.s1.rw = c.s0.v & reg_wr_dec;
      n.s1.mr = c.s0.v & mem_read_dec;
      n.s0 = f;
    end
    if (interupt_sel) begin
      n.epc = c.s1.v ? c.s1.pc : (c.s0.v ? c.s0.pc : pc_fetch);
    end
    return n;
  endfunction

  // Reference model follows the same clock and asynchronous reset as the DUT.
  always @(posedge clk or negedge reset) begin
    if (!reset) m <= reset_model();
    else        m <= step(m);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    vectors++;
    chk("inst_dec",   inst_dec,          m.s0.inst);
    chk("pc_dec",     pc_dec,            m.s0.pc);
    chk("inst_exec",  inst_exec,         m.s1.inst);
    chk("pc_exec",    pc_exec,           m.s1.pc);
    chk("valid_exec", 32'(valid_exec),   32'(m.s1.v));
    chk("mem_read",   32'(mem_read),     32'(m.s1.mr));
    chk("inst_mem",   inst_mem,          m.s2.inst);
    chk("valid_mem",  32'(valid_mem),    32'(m.s2.v));
    chk("reg_wr",     32'(reg_wr),       32'(m.s2.rw));
    chk("epc",        epc,               m.epc);
    chk("stall_cnt",  32'(stall_cnt),    m.sc);
    chk("flush_cnt",  32'(flush_cnt),    m.fc);
  end

  task automatic drive(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rw, input logic mr, input logic st,
                       input logic fl, input logic irq);
    fetch_valid = fv; inst_fetch = ins; pc_fetch = pc;
    reg_wr_dec = rw; mem_read_dec = mr;
    stall = st; flush_sel = fl; interupt_sel = irq;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    fetch_valid = 1'b0; inst_fetch = 32'h0; pc_fetch = 32'h0;
    reg_wr_dec = 1'b0; mem_read_dec = 1'b0;
    stall = 1'b0; flush_sel = 1'b0; interupt_sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_inst_exec", inst_exec, 32'h0000_0013);
    chk("rst_inst_mem",  inst_mem,  32'h0000_0013);
    chk("rst_reg_wr",    32'(reg_wr),   32'h0);
    chk("rst_mem_read",  32'(mem_read), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
    reset = 1'b1;

    // Streaming A, B, C.
    drive(1'b1, 32'hA000_00A1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stream_dec_A", inst_dec, 32'hA000_00A1);
    drive(1'b1, 32'hB000_00B2, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hC000_00C3, 32'h0000_0108, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stream_mem_A", inst_mem, 32'hA000_00A1);
    chk("stream_vmem_A", 32'(valid_mem), 32'h1);
    chk("stream_rw_A", 32'(reg_wr), 32'h1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stream_mem_B", inst_mem, 32'hB000_00B2);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stream_mem_C", inst_mem, 32'hC000_00C3);
    chk("stream_vmem_C", 32'(valid_mem), 32'h1);

    // Load-use stall.
    drive(1'b1, 32'h0000_2083, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0011_0133, 32'h0000_0204, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_mem_read", 32'(mem_read), 32'h1);
    drive(1'b1, 32'h0022_0233, 32'h0000_0208, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lu_dec_hold", inst_dec, 32'h0011_0133);
    chk("lu_exec_nop", inst_exec, 32'h0000_0013);
    chk("lu_mem_load", inst_mem, 32'h0000_2083);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'h1);

    // Branch flush together with stall.
    drive(1'b1, 32'h0033_0333, 32'h0000_020C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("br_dec_nop", inst_dec, 32'h0000_0013);
    chk("br_exec_nop", inst_exec, 32'h0000_0013);
    chk("br_flush_cnt", 32'(flush_cnt), 32'h1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'h1);

    // Interrupt with a valid instruction in ID/EX, then with empty and IF/ID-only pipelines.
    drive(1'b1, 32'h0044_0433, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0055_0533, 32'h0000_0044, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("irq_pc_exec", pc_exec, 32'h0000_0040);
    drive(1'b1, 32'h0066_0633, 32'h0000_0048, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("irq_epc_exec", epc, 32'h0000_0040);
    chk("irq_dec_nop", inst_dec, 32'h0000_0013);
    chk("irq_exec_nop", inst_exec, 32'h0000_0013);
    chk("irq_flush_cnt", 32'(flush_cnt), 32'h2);
    drive(1'b1, 32'h0077_0733, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("irq_epc_fetch", epc, 32'h0000_0080);
    drive(1'b1, 32'h0088_0833, 32'h0000_0090, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0099_0933, 32'h0000_00A0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("irq_epc_dec", epc, 32'h0000_0090);
    chk("irq_flush_cnt4", 32'(flush_cnt), 32'h4);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset between clock edges.
    #2 reset = 1'b0;
    #1;
    chk("arst_inst_dec", inst_dec, 32'h0000_0013);
    chk("arst_inst_mem", inst_mem, 32'h0000_0013);
    chk("arst_valid_mem", 32'(valid_mem), 32'h0);
    chk("arst_epc", epc, 32'h0);
    chk("arst_stall_cnt", 32'(stall_cnt), 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Counter saturation under a long stall.
    for (int i = 0; i < 65541; i++) begin
      drive(1'b1, $urandom, $urandom, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("sat_stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    chk("sat_flush_cnt", 32'(flush_cnt), 32'h0);
    chk("sat_exec_nop", inst_exec, 32'h0000_0013);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
